decoder_2to4_reg: RTL and testbench
===================================

Name: decoder_2to4_reg

Overview:
- Registered 2-to-4 one-hot decoder with active-high outputs.
- Select inputs a (MSB) and b (LSB) pick exactly one of y1..y4 per enabled cycle.
- Sits between a control-select producer and four downstream enables.
- Adds an input enable, an output valid flag and optional per-output hit counters.

Parameters:
- CNT_W, 8, width of each per-output hit counter; used only when the optional feature is compiled in; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  decode enable; the select is captured only when high.
- a  input  1  select MSB.
- b  input  1  select LSB.
- y1  output  1  high when {a,b}=2'b00 was decoded.
- y2  output  1  high when {a,b}=2'b01 was decoded.
- y3  output  1  high when {a,b}=2'b10 was decoded.
- y4  output  1  high when {a,b}=2'b11 was decoded.
- valid  output  1  high when y1..y4 hold a decoded result.
- onehot_err  output  1  registered sticky flag; set if the registered outputs are ever not one-hot while valid=1.

Behaviour:
- Reset (rst high, asynchronous, any time): y1..y4=0, valid=0, onehot_err=0, counters=0. Outputs stay 0 while rst is high.
- Release of rst is sampled synchronously; the first capture happens on the first clk rising edge with rst low.
- Latency is 1 cycle. At a rising edge with en=1, {y1,y2,y3,y4} takes the decode of {a,b} and valid becomes 1.
- Decode map:
  - 00 gives y1.
  - 01 gives y2.
  - 10 gives y3.
  - 11 gives y4.
- At a rising edge with en=0, y1..y4 clear to 0 and valid becomes 0. Outputs do not hold their previous value.
- While valid=1, exactly one of y1..y4 is high. While valid=0, all four are low.
- Back-to-back enabled cycles each produce a new result; there is no stall or backpressure.
- The combinational decode is pure. Outputs change only at clk edges or on rst assertion.
- onehot_err is a safety check. It is set when valid=1 and popcount(y1..y4)!=1, and clears only on rst. In a correct design it never sets.
- If rst asserts mid-stream, the in-flight result is discarded.

Optional Feature:
- Macro: DECODER_HIT_CNT_EN.
- With the macro defined:
  - Four extra outputs hit_cnt1..hit_cnt4, each output, CNT_W bits.
  - The counter matching the output decoded at that edge increments by 1 on each enabled edge.
  - Counters saturate at all-ones (no wrap) and reset to 0.
  - When en=0 the counters hold.
- Without the macro: no counter ports or logic exist, and the remaining behaviour is identical.

Decomposition:
- Package decoder_pkg holds:
  - typedef sel_t: 2-bit logic, with a as MSB.
  - typedef onehot_t: 4-bit logic, ordered {y1,y2,y3,y4}.
  - localparams for the four one-hot codes: 4'b1000, 4'b0100, 4'b0010, 4'b0001.
  - A function decode(sel_t) returning onehot_t.
- One sub-module, decoder_hit_counter: a saturating CNT_W counter with clk, rst, inc; four instances are generated under DECODER_HIT_CNT_EN.

Test Plan:
- Reset: assert rst mid-run with y3=1 -> y1..y4=0, valid=0 immediately without waiting for clk; after release, stays 0 until the first enabled edge.
- Exhaustive sweep: en=1; drive {a,b}=00,01,10,11 on consecutive edges -> one cycle later y1..y4 = 1000, 0100, 0010, 0001 respectively, valid=1 each cycle, onehot_err=0.
- Enable gating: {a,b}=11 with en=0 for 3 cycles -> all y=0 and valid=0; raise en -> y4=1 on the next edge.
- Back-to-back and random: 1000 random {a,b,en} vectors -> outputs match the reference decode delayed one cycle; exactly one high whenever valid=1.
- Counter saturation (DECODER_HIT_CNT_EN, CNT_W=2): decode 00 five times -> hit_cnt1 = 1, 2, 3, 3, 3 and the other counters stay 0; rst clears hit_cnt1 to 0.
- Build without DECODER_HIT_CNT_EN -> compiles with no hit_cnt ports; sweep results are identical to the exhaustive sweep above.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared select/one-hot types and the pure 2-to-4 decode used by decoder_2to4_reg.
package decoder_pkg;

  typedef logic [1:0] sel_t;     // {a, b}, a is the MSB
  typedef logic [3:0] onehot_t;  // {y1, y2, y3, y4}

  localparam onehot_t OH_Y1 = 4'b1000;
  localparam onehot_t OH_Y2 = 4'b0100;
  localparam onehot_t OH_Y3 = 4'b0010;
  localparam onehot_t OH_Y4 = 4'b0001;

  function automatic onehot_t decode(input sel_t sel);
    onehot_t result;
    case (sel)
      2'b00:   result = OH_Y1;
      2'b01:   result = OH_Y2;
      2'b10:   result = OH_Y3;
      default: result = OH_Y4;
    endcase
    return result;
  endfunction

  function automatic logic [2:0] popcount(input onehot_t value);
    logic [2:0] count;
    count = 3'd0;
    for (int i = 0; i < 4; i++) begin
      count = count + {2'b00, value[i]};
    end
    return count;
  endfunction

endpackage

// File: rtl/decoder_hit_counter.sv
// Saturating up-counter: advances by one on each clk edge with inc high, sticks at all-ones.
module decoder_hit_counter
  import decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_saturated;

  assign w_saturated = &r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && !w_saturated) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/decoder_2to4_reg.sv
// Registered 2-to-4 one-hot decoder with enable, valid flag and sticky one-hot check.
// Optional per-output saturating hit counters are built when DECODER_HIT_CNT_EN is defined.
module decoder_2to4_reg
  import decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic             y4,
  output logic             valid,
  output logic             onehot_err
`ifdef DECODER_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt1,
  output logic [CNT_W-1:0] hit_cnt2,
  output logic [CNT_W-1:0] hit_cnt3,
  output logic [CNT_W-1:0] hit_cnt4
`endif
);

  sel_t    w_sel;
  onehot_t w_decode;
  onehot_t r_y;
  logic    r_valid;
  logic    r_onehot_err;
  logic    w_onehot_bad;

  assign w_sel    = {a, b};
  assign w_decode = en ? decode(w_sel) : '0;

  // A disabled edge clears the outputs rather than holding them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_y     <= w_decode;
      r_valid <= en;
    end
  end

  assign w_onehot_bad = r_valid && (popcount(r_y) != 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_onehot_err <= 1'b0;
    end else if (w_onehot_bad) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign {y1, y2, y3, y4} = r_y;
  assign valid            = r_valid;
  assign onehot_err       = r_onehot_err;

  // Out-of-range widths elaborate this marker block so they stand out in the hierarchy.
  if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_w_out_of_range
  end

`ifdef DECODER_HIT_CNT_EN
  logic [CNT_W-1:0] w_hit_cnt [4];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_hit_cnt
    // Counter gi tracks y(gi+1), which sits at bit 3-gi of the one-hot vector.
    decoder_hit_counter #(
      .CNT_W (CNT_W)
    ) u_hit_counter (
      .clk (clk),
      .rst (rst),
      .inc (w_decode[3-gi]),
      .cnt (w_hit_cnt[gi])
    );
  end

  assign hit_cnt1 = w_hit_cnt[0];
  assign hit_cnt2 = w_hit_cnt[1];
  assign hit_cnt3 = w_hit_cnt[2];
  assign hit_cnt4 = w_hit_cnt[3];
`endif

endmodule

// File: tb/tb_decoder_2to4_reg.sv
// Self-checking bench for decoder_2to4_reg: directed reset/sweep/gating steps plus random vectors.
// Define DECODER_HIT_CNT_EN when building to also check the hit counters.
module tb_decoder_2to4_reg;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic a;
  logic b;
  logic y1, y2, y3, y4;
  logic valid;
  logic onehot_err;
`ifdef DECODER_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt1, hit_cnt2, hit_cnt3, hit_cnt4;
`endif

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_y;
  logic       exp_valid;
  int         exp_cnt [4];

  always #5 clk = ~clk;

  decoder_2to4_reg #(
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .a          (a),
    .b          (b),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .y4         (y4),
    .valid      (valid),
    .onehot_err (onehot_err)
`ifdef DECODER_HIT_CNT_EN
    ,
    .hit_cnt1   (hit_cnt1),
    .hit_cnt2   (hit_cnt2),
    .hit_cnt3   (hit_cnt3),
    .hit_cnt4   (hit_cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic model_reset();
    exp_y     = 4'b0000;
    exp_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".y"}, {28'd0, y1, y2, y3, y4}, {28'd0, exp_y});
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_valid});
    check({tag, ".onehot_err"}, {31'd0, onehot_err}, 32'd0);
    if (valid === 1'b1) begin
      check({tag, ".exactly_one"}, $countones({y1, y2, y3, y4}), 32'd1);
    end
`ifdef DECODER_HIT_CNT_EN
    check({tag, ".hit_cnt1"}, {30'd0, hit_cnt1}, exp_cnt[0]);
    check({tag, ".hit_cnt2"}, {30'd0, hit_cnt2}, exp_cnt[1]);
    check({tag, ".hit_cnt3"}, {30'd0, hit_cnt3}, exp_cnt[2]);
    check({tag, ".hit_cnt4"}, {30'd0, hit_cnt4}, exp_cnt[3]);
`endif
  endtask

  // Apply one vector, let one edge pass, then predict and compare.
  task automatic step(input string tag, input logic e, input logic [1:0] sel);
    en     = e;
    {a, b} = sel;
    @(posedge clk);
    #1;
    if (e) begin
      exp_y        = 4'(8 >> sel);
      exp_valid    = 1'b1;
      exp_cnt[sel] = (exp_cnt[sel] < CNT_MAX) ? exp_cnt[sel] + 1 : CNT_MAX;
    end else begin
      exp_y     = 4'b0000;
      exp_valid = 1'b0;
    end
    $display("step %s en=%0b ab=%02b -> y=%04b valid=%0b", tag, e, sel, {y1, y2, y3, y4}, valid);
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = 1'b0;
    b   = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive sweep, back to back.
    for (int s = 0; s < 4; s++) step("sweep", 1'b1, 2'(s));

    // Asynchronous reset mid-run while y3 is high.
    step("pre_rst", 1'b1, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    $display("async reset asserted between edges");
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_idle", 1'b0, 2'b10);
    step("post_rst_idle", 1'b0, 2'b01);
    step("post_rst_first", 1'b1, 2'b10);

    // Enable gating.
    for (int i = 0; i < 3; i++) step("gate_off", 1'b0, 2'b11);
    step("gate_on", 1'b1, 2'b11);

    // Counter saturation on output y1 from a clean reset.
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("sat_y1", 1'b1, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("sat_rst");
    @(negedge clk);
    rst = 1'b0;

    // Random vectors.
    for (int i = 0; i < 1000; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
